// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - programmable VGA raster sequencer (hsync/vsync/de/x/y and line/frame pulses)
// Optional frame-boundary pause: define VGA_TIMING_FRAME_PAUSE_EN.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef VGA_TIMING_FRAME_PAUSE_EN
  input  logic             pause_req,
  output logic             paused,
`endif
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_FP_S = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SY_S = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_BP_S = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_FP_S = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SY_S = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_BP_S = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON  = (HS_POL != 0);
  localparam logic HS_OFF = ~HS_ON;
  localparam logic VS_ON  = (VS_POL != 0);
  localparam logic VS_OFF = ~VS_ON;

  typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_t;

  // Phase is fully implied by the counter value, so it is decoded rather than stored.
  function automatic phase_t phase_of(input logic [CNT_W-1:0] c,
                                      input logic [CNT_W-1:0] fp_s,
                                      input logic [CNT_W-1:0] sy_s,
                                      input logic [CNT_W-1:0] bp_s);
    phase_t p;
    if (c < fp_s)      p = PH_ACT;
    else if (c < sy_s) p = PH_FP;
    else if (c < bp_s) p = PH_SYNC;
    else               p = PH_BP;
    return p;
  endfunction

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             h_wrap, v_wrap;
  phase_t           hp_n, vp_n;
  logic             step;
  logic             go_idle;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_nxt  = h_wrap ? '0 : h_cnt + CNT_W'(1);
    v_nxt  = v_cnt;
    if (h_wrap) v_nxt = v_wrap ? '0 : v_cnt + CNT_W'(1);
    hp_n = phase_of(h_nxt, H_FP_S, H_SY_S, H_BP_S);
    vp_n = phase_of(v_nxt, V_FP_S, V_SY_S, V_BP_S);
  end

`ifdef VGA_TIMING_FRAME_PAUSE_EN
  typedef enum logic {RUN, PAUSED} ctl_t;
  ctl_t ctl_q, ctl_d;

  // While paused the counters sit at the last position, so the next step lands on (0,0).
  always_comb begin
    ctl_d   = ctl_q;
    step    = 1'b0;
    go_idle = 1'b0;
    case (ctl_q)
      RUN: begin
        if (en) begin
          if (pause_req && h_wrap && v_wrap) begin
            ctl_d   = PAUSED;
            go_idle = 1'b1;
          end else begin
            step = 1'b1;
          end
        end
      end
      PAUSED: begin
        if (en && !pause_req) begin
          ctl_d = RUN;
          step  = 1'b1;
        end
      end
      default: ctl_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q  <= RUN;
      paused <= 1'b0;
    end else begin
      ctl_q  <= ctl_d;
      paused <= (ctl_d == PAUSED);
    end
  end
`else
  always_comb begin
    step    = en;
    go_idle = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      hsync       <= HS_OFF;
      vsync       <= VS_OFF;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (step) begin
        h_cnt       <= h_nxt;
        v_cnt       <= v_nxt;
        de          <= (hp_n == PH_ACT) && (vp_n == PH_ACT);
        x           <= ((hp_n == PH_ACT) && (vp_n == PH_ACT)) ? h_nxt : '0;
        y           <= ((hp_n == PH_ACT) && (vp_n == PH_ACT)) ? v_nxt : '0;
        hsync       <= (hp_n == PH_SYNC) ? HS_ON : HS_OFF;
        vsync       <= (vp_n == PH_SYNC) ? VS_ON : VS_OFF;
        line_start  <= (h_nxt == '0) && (vp_n == PH_ACT);
        frame_start <= (h_nxt == '0) && (v_nxt == '0);
      end else if (go_idle) begin
        de    <= 1'b0;
        x     <= '0;
        y     <= '0;
        hsync <= HS_OFF;
        vsync <= VS_OFF;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - self-checking bench for vga_timing_ctrl (small, inverted-polarity and default timings)
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, pause_req;
  logic hs [3], vs [3], de [3], ls [3], fs [3], pz [3];
  logic [10:0] xo [3], yo [3];

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
    bit hp, vp;
  } cfg_t;

  typedef struct packed {
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic        pz;
  } obs_t;

  typedef struct {
    bit   e;
    obs_t o;
  } vec_t;

  cfg_t cfg [3];
  int   pos [3];
  bit   landed [3];
  bit   mpaused [3];
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef VGA_TIMING_FRAME_PAUSE_EN
  `define PAUSE_PORTS(i) .pause_req(pause_req), .paused(pz[i]),
`else
  `define PAUSE_PORTS(i)
  assign pz[0] = 1'b0;
  assign pz[1] = 1'b0;
  assign pz[2] = 1'b0;
`endif

  vga_timing_ctrl #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .HS_POL(0), .VS_POL(0), .CNT_W(11)) u_s (
    .clk(clk), .rst_n(rst_n), .en(en), `PAUSE_PORTS(0)
    .hsync(hs[0]), .vsync(vs[0]), .de(de[0]), .x(xo[0]), .y(yo[0]),
    .line_start(ls[0]), .frame_start(fs[0]));

  vga_timing_ctrl #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .HS_POL(1), .VS_POL(1), .CNT_W(11)) u_p (
    .clk(clk), .rst_n(rst_n), .en(en), `PAUSE_PORTS(1)
    .hsync(hs[1]), .vsync(vs[1]), .de(de[1]), .x(xo[1]), .y(yo[1]),
    .line_start(ls[1]), .frame_start(fs[1]));

  vga_timing_ctrl u_d (
    .clk(clk), .rst_n(rst_n), .en(en), `PAUSE_PORTS(2)
    .hsync(hs[2]), .vsync(vs[2]), .de(de[2]), .x(xo[2]), .y(yo[2]),
    .line_start(ls[2]), .frame_start(fs[2]));

  function automatic int frame_len(input int i);
    return (cfg[i].ha + cfg[i].hfp + cfg[i].hsw + cfg[i].hbp) *
           (cfg[i].va + cfg[i].vfp + cfg[i].vsw + cfg[i].vbp);
  endfunction

  function automatic obs_t get_obs(input int i);
    obs_t o;
    o.de = de[i]; o.x = xo[i]; o.y = yo[i]; o.hs = hs[i]; o.vs = vs[i];
    o.ls = ls[i]; o.fs = fs[i]; o.pz = pz[i];
    return o;
  endfunction

  function automatic obs_t mk(input bit d, input int xx, input int yy, input bit h,
                              input bit v, input bit l, input bit f);
    obs_t o;
    o.de = d; o.x = 11'(xx); o.y = 11'(yy); o.hs = h; o.vs = v;
    o.ls = l; o.fs = f; o.pz = 1'b0;
    return o;
  endfunction

  // Reference: a linear raster index split into (h, v) by division.
  function automatic obs_t model_obs(input int i);
    obs_t o;
    int ht, h, v, hs0, vs0;
    ht  = cfg[i].ha + cfg[i].hfp + cfg[i].hsw + cfg[i].hbp;
    h   = pos[i] % ht;
    v   = pos[i] / ht;
    hs0 = cfg[i].ha + cfg[i].hfp;
    vs0 = cfg[i].va + cfg[i].vfp;
    o = '0;
    o.hs = !cfg[i].hp;
    o.vs = !cfg[i].vp;
    if (mpaused[i]) begin
      o.pz = 1'b1;
      return o;
    end
    o.de = (h < cfg[i].ha) && (v < cfg[i].va);
    if (o.de) begin
      o.x = 11'(h);
      o.y = 11'(v);
    end
    if (h >= hs0 && h < hs0 + cfg[i].hsw) o.hs = cfg[i].hp;
    if (v >= vs0 && v < vs0 + cfg[i].vsw) o.vs = cfg[i].vp;
    o.ls = landed[i] && (h == 0) && (v < cfg[i].va);
    o.fs = landed[i] && (pos[i] == 0);
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pos[i] = frame_len(i) - 1;
      landed[i] = 1'b0;
      mpaused[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit e, input bit pr);
    for (int i = 0; i < 3; i++) begin
      landed[i] = 1'b0;
      if (e) begin
`ifdef VGA_TIMING_FRAME_PAUSE_EN
        if (mpaused[i]) begin
          if (!pr) begin
            mpaused[i] = 1'b0;
            pos[i] = 0;
            landed[i] = 1'b1;
          end
        end else if (pr && pos[i] == frame_len(i) - 1) begin
          mpaused[i] = 1'b1;
        end else begin
          pos[i] = (pos[i] + 1) % frame_len(i);
          landed[i] = 1'b1;
        end
`else
        pos[i] = (pos[i] + 1) % frame_len(i);
        landed[i] = 1'b1;
        if (pr) landed[i] = 1'b1;
`endif
      end
    end
  endtask

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name);
    check({name, "_s"}, get_obs(0), model_obs(0));
    check({name, "_p"}, get_obs(1), model_obs(1));
    check({name, "_d"}, get_obs(2), model_obs(2));
  endtask

  task automatic tick(input bit e);
    en = e;
    @(posedge clk);
    #1;
    model_step(e, pause_req);
    check_all("model");
  endtask

  vec_t vecs [11];
  int   cnt, maxx, lows;
  bit   seen;

  initial begin
    cfg[0] = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0};
    cfg[1] = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
    cfg[2] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};

    vecs[0]  = '{1'b1, mk(1, 0, 0, 1, 1, 1, 1)};
    vecs[1]  = '{1'b1, mk(1, 1, 0, 1, 1, 0, 0)};
    vecs[2]  = '{1'b0, mk(1, 1, 0, 1, 1, 0, 0)};
    vecs[3]  = '{1'b1, mk(1, 2, 0, 1, 1, 0, 0)};
    vecs[4]  = '{1'b1, mk(1, 3, 0, 1, 1, 0, 0)};
    vecs[5]  = '{1'b1, mk(0, 0, 0, 1, 1, 0, 0)};
    vecs[6]  = '{1'b1, mk(0, 0, 0, 0, 1, 0, 0)};
    vecs[7]  = '{1'b0, mk(0, 0, 0, 0, 1, 0, 0)};
    vecs[8]  = '{1'b1, mk(0, 0, 0, 0, 1, 0, 0)};
    vecs[9]  = '{1'b1, mk(0, 0, 0, 1, 1, 0, 0)};
    vecs[10] = '{1'b1, mk(1, 0, 1, 1, 1, 1, 0)};

    rst_n = 1'b0;
    en = 1'b0;
    pause_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    check("reset_const", get_obs(0), mk(0, 0, 0, 1, 1, 0, 0));
    rst_n = 1'b1;

    for (int k = 0; k < 11; k++) begin
      tick(vecs[k].e);
      check($sformatf("vec%0d", k), get_obs(0), vecs[k].o);
    end

    // Frame period with en held high.
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick(1'b1);
      seen = fs[0];
    end
    cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick(1'b1);
      cnt++;
      seen = fs[0];
    end
    check_int("period_en1", cnt, 48);

    // Frame period with en alternating.
    cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      tick(k[0]);
      cnt++;
      seen = fs[0];
    end
    check_int("period_toggle", cnt, 96);

    for (int k = 0; k < 3000; k++) begin
`ifdef VGA_TIMING_FRAME_PAUSE_EN
      pause_req = ($urandom_range(0, 7) == 0);
`endif
      tick($urandom_range(0, 3) != 0);
    end
    pause_req = 1'b0;

    // Leave any paused state before the reset-position hunt.
    tick(1'b1);

    // Asynchronous reset landing mid-frame at h=2, v=1 of the small timing.
    seen = (pos[0] == 10) && !mpaused[0];
    for (int k = 0; k < 200 && !seen; k++) begin
      tick(1'b1);
      seen = (pos[0] == 10);
    end
    check_int("reach_h2v1", int'(seen), 1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset_s", get_obs(0), mk(0, 0, 0, 1, 1, 0, 0));
    check_all("midreset");
    #1;
    rst_n = 1'b1;
    tick(1'b1);
    check("restart_s", get_obs(0), mk(1, 0, 0, 1, 1, 1, 1));

    // Default timing: a couple of full lines.
    maxx = 0;
    lows = 0;
    for (int k = 0; k < 1600; k++) begin
      tick(1'b1);
      if (de[2] && int'(xo[2]) > maxx) maxx = int'(xo[2]);
      if (k >= 800 && !hs[2]) lows++;
    end
    check_int("def_max_x", maxx, 639);
    check_int("def_hsync_low", lows, 96);

`ifdef VGA_TIMING_FRAME_PAUSE_EN
    pause_req = 1'b1;
    repeat (5) tick(1'b1);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick(1'b1);
      seen = pz[0];
    end
    check_int("pause_reached", int'(seen), 1);
    repeat (10) tick(1'b1);
    check("paused_idle", get_obs(0), model_obs(0));
    pause_req = 1'b0;
    tick(1'b0);
    tick(1'b1);
    check("resume_s", get_obs(0), mk(1, 0, 0, 1, 1, 1, 1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Programmable VGA raster sequencer. Walks a horizontal/vertical beat counter pair through the phases ACTIVE → FRONT PORCH → SYNC → BACK PORCH, and emits registered hsync, vsync, data-enable and pixel coordinates. It sits between the pixel-clock enable source and the pattern/pixel generators of the VGA display path, and it is the single scheduler all display blocks key off.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of hsync (0 = active-low)
VS_POL, 0, asserted level of vsync
CNT_W, 11, width of internal counters and x/y outputs

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
en  in  1  pixel-advance strobe; one raster position per clk with en=1
hsync  out  1  horizontal sync, level per HS_POL
vsync  out  1  vertical sync, level per VS_POL
de  out  1  high while the position is inside the active area
x  out  CNT_W  active-area column; 0 when de=0
y  out  CNT_W  active-area row; 0 when de=0
line_start  out  1  one-clk pulse when h position becomes 0 on an active row
frame_start  out  1  one-clk pulse when position becomes (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must be ≤ 2^CNT_W.
- Reset (async): h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1. Outputs: de=0, x=0, y=0, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0.
- With en=1 on a clk edge:
  - h_cnt increments.
  - When h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - When v_cnt = V_TOTAL-1, v_cnt wraps to 0.
  - The first en after reset therefore lands on (0,0).
- All outputs are registered and decoded from the next position, so every output on a given cycle describes the same (h_cnt, v_cnt). Latency from en edge to outputs: 0 cycles beyond that edge.
- Horizontal FSM, state implied by h_cnt:
  - H_ACT for [0, H_ACTIVE-1]
  - H_FP for [H_ACTIVE, H_ACTIVE+H_FP-1]
  - H_SYNC for the next H_SYNC counts
  - H_BP for the remainder
  - Vertical FSM is identical on v_cnt.
- Output decode:
  - de = H_ACT && V_ACT.
  - x = h_cnt and y = v_cnt when de, else 0.
  - hsync = HS_POL during H_SYNC.
  - vsync = VS_POL during V_SYNC; changes only on the position where h_cnt becomes 0.
- line_start = 1 for one clk when the position becomes h=0 with v < V_ACTIVE. frame_start = 1 for one clk when the position becomes (0,0).
- en=0: counters and level outputs hold; line_start and frame_start forced to 0.
- Reset mid-frame: immediate return to reset values; the next en starts a fresh frame with frame_start.

Optional Feature:
VGA_TIMING_FRAME_PAUSE_EN.
- Defined: adds input pause_req (1 bit) and output paused (1 bit, reset 0), plus a control FSM RUN / PAUSED.
- In RUN: if pause_req=1 on the en cycle that would wrap (H_TOTAL-1, V_TOTAL-1) → (0,0), go to PAUSED instead. Counters hold at the end position, de=0, sync outputs inactive, paused=1, no frame_start.
- In PAUSED: on the first en cycle with pause_req=0, go to RUN, load (0,0), pulse frame_start, set paused=0.
- Mid-frame pause_req has no effect until the frame boundary.
- Undefined: ports absent; behaviour as above, free-running.

Test Plan:
1. Small params (H 4/1/2/1, V 3/1/1/1, HS_POL=VS_POL=0), en tied 1 after reset → frame_start on 1st en; de high 4 of 8 clks on lines 0-2; hsync=0 at h=5,6; vsync=0 for all of line 4; frame period 48 clks.
2. Defaults, en=1 → hsync low 96 clks per 800-clk line; vsync low 1600 clks per 420000-clk frame; x counts 0..639, y reaches 479.
3. Small params, en toggled 1/0 → positions advance only on en cycles; pulses never coincide with en=0; frame period 96 clks.
4. Reset asserted at h=2, v=1 (small params) → outputs immediately de=0, hsync=1, vsync=1; first en after release gives frame_start=1, x=0, y=0, de=1.
5. HS_POL=1, VS_POL=1 → sync waveforms inverted relative to scenario 1; de, x and y unchanged.
6. With VGA_TIMING_FRAME_PAUSE_EN: pause_req raised mid-frame → frame completes, then paused=1 and outputs idle; pause_req dropped → next en gives frame_start=1 and paused=0.
